// File: rtl/key_material_sequencer.sv
// Loads key, counter and nonce words into the cipher core state, then launches one block.
// Each word comes from either the external chunk stream or the TRNG.
module key_material_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic        use_streamed_key,
    input  logic        use_streamed_nonce,
    input  logic        use_streamed_counter,
    input  logic        chunk_valid,
    input  logic [1:0]  chunk_type,
    input  logic [31:0] chunk,
    input  logic [31:0] trng_data,
    input  logic        trng_ready,
    input  logic        core_ready,
    input  logic        core_done,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        chunk_request,
    output logic [1:0]  request_type,
    output logic [4:0]  chunk_index,
    output logic        trng_request,
    output logic        cfg_we,
    output logic [3:0]  cfg_addr,
    output logic [31:0] cfg_data,
    output logic        core_start
);

    // state     | meaning
    // IDLE      | waiting for start
    // FETCH     | collecting words; cfg_we_q marks the write cycle of the last accepted word
    // LAUNCH    | all 12 words written, waiting for core_ready
    // WAIT_CORE | core running, waiting for core_done
    // DONE      | done pulse
    // ERR       | error pulse after a chunk type mismatch
    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_FETCH     = 3'd1;
    localparam logic [2:0] S_LAUNCH    = 3'd2;
    localparam logic [2:0] S_WAIT_CORE = 3'd3;
    localparam logic [2:0] S_DONE      = 3'd4;
    localparam logic [2:0] S_ERR       = 3'd5;

    // Phase encodings double as the chunk_type / request_type codes.
    localparam logic [1:0] PH_KEY     = 2'd0;
    localparam logic [1:0] PH_NONCE   = 2'd1;
    localparam logic [1:0] PH_COUNTER = 2'd2;

    logic [2:0]  state;
    logic [2:0]  state_next;
    logic [1:0]  phase;
    logic [2:0]  word;
    logic        sel_key;
    logic        sel_nonce;
    logic        sel_counter;
    logic        cfg_we_q;
    logic [3:0]  cfg_addr_q;
    logic [31:0] cfg_data_q;

    logic        streamed;
    logic        fetching;
    logic        chunk_req_i;
    logic        trng_req_i;
    logic        take_chunk;
    logic        take_trng;
    logic        take_zero;
    logic        accept;
    logic        mismatch;
    logic        last_word;
    logic [3:0]  accept_addr;
    logic [31:0] accept_data;

    always_comb begin
        streamed = 1'b0;
        case (phase)
            PH_KEY:     streamed = sel_key;
            PH_NONCE:   streamed = sel_nonce;
            PH_COUNTER: streamed = sel_counter;
            default:    streamed = 1'b0;
        endcase
    end

    // No new request during the write cycle of the previous word.
    assign fetching    = (state == S_FETCH) && !cfg_we_q;
    assign chunk_req_i = fetching && streamed;
    assign trng_req_i  = fetching && !streamed && (phase != PH_COUNTER);
    assign take_chunk  = chunk_req_i && chunk_valid && (chunk_type == phase);
    assign mismatch    = chunk_req_i && chunk_valid && (chunk_type != phase);
    assign take_trng   = trng_req_i && trng_ready;
    assign take_zero   = fetching && !streamed && (phase == PH_COUNTER);
    assign accept      = take_chunk || take_trng || take_zero;
    assign last_word   = (phase == PH_NONCE) && (word == 3'd2);

    always_comb begin
        accept_addr = 4'd0;
        case (phase)
            PH_KEY:     accept_addr = 4'd4 + {1'b0, word};
            PH_COUNTER: accept_addr = 4'd12;
            PH_NONCE:   accept_addr = 4'd13 + {1'b0, word};
            default:    accept_addr = 4'd0;
        endcase
    end

    always_comb begin
        accept_data = 32'h0;
        if (take_chunk)
            accept_data = chunk;
        else if (take_trng)
            accept_data = trng_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (abort) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE:      if (start) state_next = S_FETCH;
                S_FETCH: begin
                    if (cfg_we_q && last_word)
                        state_next = S_LAUNCH;
                    else if (mismatch)
                        state_next = S_ERR;
                end
                S_LAUNCH:    if (core_ready) state_next = S_WAIT_CORE;
                S_WAIT_CORE: if (core_done) state_next = S_DONE;
                S_DONE:      state_next = S_IDLE;
                S_ERR:       state_next = S_IDLE;
                default:     state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase       <= PH_KEY;
            word        <= 3'd0;
            sel_key     <= 1'b0;
            sel_nonce   <= 1'b0;
            sel_counter <= 1'b0;
            cfg_we_q    <= 1'b0;
            cfg_addr_q  <= 4'd0;
            cfg_data_q  <= 32'h0;
        end else begin
            cfg_we_q <= 1'b0;
            if (abort) begin
                cfg_we_q <= 1'b0;
            end else if ((state == S_IDLE) && start) begin
                sel_key     <= use_streamed_key;
                sel_nonce   <= use_streamed_nonce;
                sel_counter <= use_streamed_counter;
                phase       <= PH_KEY;
                word        <= 3'd0;
            end else if (state == S_FETCH) begin
                if (cfg_we_q) begin
                    // Advance position once the previous word has been written.
                    case (phase)
                        PH_KEY: begin
                            if (word == 3'd7) begin
                                phase <= PH_COUNTER;
                                word  <= 3'd0;
                            end else begin
                                word <= word + 3'd1;
                            end
                        end
                        PH_COUNTER: begin
                            phase <= PH_NONCE;
                            word  <= 3'd0;
                        end
                        PH_NONCE: if (!last_word) word <= word + 3'd1;
                        default: begin
                            phase <= PH_KEY;
                            word  <= 3'd0;
                        end
                    endcase
                end else if (accept) begin
                    cfg_we_q   <= 1'b1;
                    cfg_addr_q <= accept_addr;
                    cfg_data_q <= accept_data;
                end
            end
        end
    end

    always_comb begin
        busy          = (state != S_IDLE);
        done          = (state == S_DONE);
        error         = (state == S_ERR);
        chunk_request = chunk_req_i;
        trng_request  = trng_req_i;
        request_type  = (state == S_FETCH) ? phase : 2'd0;
        chunk_index   = (state == S_FETCH) ? {2'b00, word} : 5'd0;
        cfg_we        = cfg_we_q;
        cfg_addr      = cfg_addr_q;
        cfg_data      = cfg_data_q;
        core_start    = (state == S_LAUNCH) && core_ready && !abort;
    end

endmodule

// File: doc/key_material_sequencer.md
KEY_MATERIAL_SEQUENCER -- requirements
Module: key_material_sequencer

Interface
REQ-001 SHALL have ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin load sequence; sampled in IDLE only.
- abort  in  1  synchronous abort.
- use_streamed_key / use_streamed_nonce / use_streamed_counter  in  1 each  source select; sampled at start.
- chunk_valid  in  1  external chunk word valid.
- chunk_type  in  2  type of offered chunk: 0=key, 1=nonce, 2=counter.
- chunk  in  32  external chunk word.
- trng_data  in  32  TRNG word.
- trng_ready  in  1  TRNG word valid.
- core_ready  in  1  cipher core idle.
- core_done  in  1  cipher core block complete, 1-cycle pulse.
- busy  out  1  sequence in progress.
- done  out  1  1-cycle completion pulse.
- error  out  1  1-cycle type-mismatch pulse.
- chunk_request  out  1  requesting external chunk word.
- request_type  out  2  requested chunk type.
- chunk_index  out  5  word index within current phase.
- trng_request  out  1  requesting TRNG word.
- cfg_we  out  1  core state-word write strobe.
- cfg_addr  out  4  core state-word address.
- cfg_data  out  32  core state-word data.
- core_start  out  1  1-cycle core launch pulse.

Function
REQ-002 SHALL implement states IDLE, FETCH, LAUNCH, WAIT_CORE, DONE, ERR.
REQ-003 SHALL, in IDLE on start=1 and abort=0, latch the three use_streamed_* bits, set phase=KEY and word=0, and enter FETCH next cycle.
REQ-004 SHALL load phases in order KEY (8 words, cfg_addr 4..11), COUNTER (1 word, cfg_addr 12), NONCE (3 words, cfg_addr 13..15).
REQ-005 SHALL, in FETCH for a streamed phase, hold chunk_request=1, request_type=phase code and chunk_index=word until acceptance.
REQ-006 SHALL accept a streamed word when chunk_request=1 and chunk_valid=1 in the same cycle.
REQ-007 SHALL, for a non-streamed KEY or NONCE phase, hold trng_request=1 and accept when trng_ready=1.
REQ-008 SHALL, for a non-streamed COUNTER phase, write 32'h0 after one FETCH cycle with no request asserted.
REQ-009 SHALL register each accepted word and pulse cfg_we with the matching cfg_addr/cfg_data exactly 1 cycle after acceptance.
REQ-010 SHALL deassert the request in the cycle after acceptance and re-assert it for the next word no earlier than that cycle.
REQ-011 SHALL, on an accepted chunk whose chunk_type differs from request_type, write nothing, enter ERR, pulse error 1 cycle, then return to IDLE.
REQ-012 SHALL ignore chunk_valid while chunk_request=0 and trng_ready while trng_request=0.
REQ-013 SHALL enter LAUNCH after the 12th cfg_we.
REQ-014 SHALL, in LAUNCH, pulse core_start in the first cycle core_ready=1, then enter WAIT_CORE.
REQ-015 SHALL, in WAIT_CORE on core_done=1, enter DONE; DONE SHALL pulse done 1 cycle and return to IDLE.
REQ-016 SHALL hold busy=1 in every state except IDLE.
REQ-017 SHALL ignore start in any state other than IDLE.
REQ-018 SHALL, on abort=1 in any state, return to IDLE next cycle with no done, no core_start and no further cfg_we.
REQ-019 SHALL, when start and abort are both 1 in IDLE, give abort priority and remain in IDLE.
REQ-020 SHALL keep chunk_index within 0..7; chunk_index[4:3] SHALL always be 0.

Reset
REQ-021 SHALL, while rst=1, asynchronously force state IDLE and drive every output to 0, including cfg_addr and cfg_data.
REQ-022 SHALL, on reset mid-sequence, discard all partial progress; the next start SHALL restart at KEY word 0.

Verification
REQ-023 All streamed, chunk_valid tied high with matching types -> 12 cfg_we at addr 4..15, then core_start when core_ready=1, then done 1 cycle after core_done.
REQ-024 No streaming, trng_data=32'hDEADBEEF, trng_ready=1 -> addr 4..11 and 13..15 get DEADBEEF, addr 12 gets 0, 11 trng_request handshakes, no chunk_request.
REQ-025 Streamed key, chunk_type=1 offered at KEY word 3 -> error pulse, only 3 cfg_we (addr 4..6), return to IDLE, no core_start.
REQ-026 abort asserted during NONCE word 1 -> IDLE next cycle, busy=0, no done, no core_start.
REQ-027 rst asserted during WAIT_CORE, then new start -> all outputs 0 during reset, full sequence restarts at cfg_addr 4.
REQ-028 core_ready held 0 for 20 cycles in LAUNCH -> no core_start and busy=1 throughout; core_start on the first cycle core_ready=1.
